// File: rtl/rect_copy_controller.sv
// Rectangle-table copy controller.
// Streams 64 rects (4 batches of 16 rects x 5 fields) out of main memory.
// Each batch is followed by a full X sweep and a full Y sweep. A sideband
// tag stream trails the internal state by one cycle so that it lines up
// with the memory read data.
module rect_copy_controller #(
    parameter logic [15:0] RECT_BASE = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        copy_start,
    output logic [2:0]  fsm_state,
    output logic [9:0]  coord_generator,
    output logic [3:0]  rect_counter,
    output logic [1:0]  batch_counter,
    output logic        batch_completed,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_SWEEP_X = 2'd2,
        S_SWEEP_Y = 2'd3
    } state_t;

    localparam logic [2:0] LAST_FIELD = 3'd4;
    localparam logic [3:0] LAST_RECT  = 4'd15;
    localparam logic [1:0] LAST_BATCH = 2'd3;
    localparam logic [9:0] LAST_COORD = 10'd1023;

    // Internal sequencer state (describes the current cycle).
    state_t      state_q;
    logic [2:0]  field_q;
    logic [3:0]  rect_q;
    logic [1:0]  batch_q;
    logic [9:0]  coord_q;
    logic        mem_rd_q;
    logic [15:0] mem_addr_q;
    logic        copy_start_q;
    logic        busy_q;

    // Sideband stream (internal state delayed one cycle).
    logic [2:0]  fsm_state_q,  fsm_state_d;
    logic [9:0]  coord_q2,     coord_d;
    logic [3:0]  rect_sb_q,    rect_sb_d;
    logic [1:0]  batch_sb_q,   batch_sb_d;
    logic        bc_q,         bc_d;
    logic        done_q,       done_d;

    // Main FSM. Addresses simply increment across the whole copy because the
    // table is laid out contiguously; sweeps hold the last fetched address.
    // busy_q stays high one extra cycle after the sequencer returns to IDLE
    // so that the trailing sideband cycle is covered, and it also blocks a
    // start from being taken during that trailing cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            field_q      <= '0;
            rect_q       <= '0;
            batch_q      <= '0;
            coord_q      <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            copy_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            copy_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= start && !busy_q;
                    if (start && !busy_q) begin
                        state_q      <= S_FETCH;
                        field_q      <= '0;
                        rect_q       <= '0;
                        batch_q      <= '0;
                        coord_q      <= '0;
                        mem_rd_q     <= 1'b1;
                        mem_addr_q   <= RECT_BASE;
                        copy_start_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    busy_q <= 1'b1;
                    if (field_q == LAST_FIELD && rect_q == LAST_RECT) begin
                        state_q  <= S_SWEEP_X;
                        field_q  <= '0;
                        rect_q   <= '0;
                        coord_q  <= '0;
                        mem_rd_q <= 1'b0;
                    end else begin
                        if (field_q == LAST_FIELD) begin
                            field_q <= '0;
                            rect_q  <= rect_q + 4'd1;
                        end else begin
                            field_q <= field_q + 3'd1;
                        end
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + 16'd1;
                    end
                end
                S_SWEEP_X: begin
                    busy_q  <= 1'b1;
                    coord_q <= coord_q + 10'd1;
                    if (coord_q == LAST_COORD) state_q <= S_SWEEP_Y;
                end
                S_SWEEP_Y: begin
                    busy_q  <= 1'b1;
                    coord_q <= coord_q + 10'd1;
                    if (coord_q == LAST_COORD) begin
                        if (batch_q == LAST_BATCH) begin
                            state_q <= S_IDLE;
                            batch_q <= '0;
                        end else begin
                            state_q    <= S_FETCH;
                            batch_q    <= batch_q + 2'd1;
                            field_q    <= '0;
                            rect_q     <= '0;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= mem_addr_q + 16'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sideband tag derived from the current internal state; zero in IDLE.
    always_comb begin
        fsm_state_d = '0;
        coord_d     = '0;
        rect_sb_d   = '0;
        batch_sb_d  = '0;
        bc_d        = 1'b0;
        case (state_q)
            S_FETCH: begin
                fsm_state_d = 3'd1 + field_q;
                rect_sb_d   = rect_q;
                batch_sb_d  = batch_q;
            end
            S_SWEEP_X: begin
                fsm_state_d = 3'd6;
                coord_d     = coord_q;
                batch_sb_d  = batch_q;
            end
            S_SWEEP_Y: begin
                fsm_state_d = 3'd7;
                coord_d     = coord_q;
                batch_sb_d  = batch_q;
                bc_d        = (coord_q == LAST_COORD);
            end
            default: ;
        endcase
        // The final batch_completed of batch 3 is the last sideband cycle.
        done_d = bc_q && (batch_sb_q == LAST_BATCH);
    end

    // Sideband register stage, one cycle behind the sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state_q <= '0;
            coord_q2    <= '0;
            rect_sb_q   <= '0;
            batch_sb_q  <= '0;
            bc_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_state_q <= fsm_state_d;
            coord_q2    <= coord_d;
            rect_sb_q   <= rect_sb_d;
            batch_sb_q  <= batch_sb_d;
            bc_q        <= bc_d;
            done_q      <= done_d;
        end
    end

    assign mem_rd          = mem_rd_q;
    assign mem_addr        = mem_addr_q;
    assign copy_start      = copy_start_q;
    assign fsm_state       = fsm_state_q;
    assign coord_generator = coord_q2;
    assign rect_counter    = rect_sb_q;
    assign batch_counter   = batch_sb_q;
    assign batch_completed = bc_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_rect_copy_controller.sv
// Directed bench for rect_copy_controller: two instances (default base and a
// base near the top of memory) share clock, reset and start.
module tb_rect_copy_controller;

    logic clk = 1'b0;
    logic reset;
    logic start;

    always #5 clk = ~clk;

    logic        rd_a, cs_a, bc_a, busy_a, done_a;
    logic [15:0] addr_a;
    logic [2:0]  fsm_a;
    logic [9:0]  crd_a;
    logic [3:0]  rect_a;
    logic [1:0]  bat_a;

    logic        rd_b, cs_b, bc_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [2:0]  fsm_b;
    logic [9:0]  crd_b;
    logic [3:0]  rect_b;
    logic [1:0]  bat_b;

    rect_copy_controller #(.RECT_BASE(16'h1000)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd(rd_a), .mem_addr(addr_a), .copy_start(cs_a),
        .fsm_state(fsm_a), .coord_generator(crd_a), .rect_counter(rect_a),
        .batch_counter(bat_a), .batch_completed(bc_a), .busy(busy_a), .done(done_a)
    );

    rect_copy_controller #(.RECT_BASE(16'hFFF0)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd(rd_b), .mem_addr(addr_b), .copy_start(cs_b),
        .fsm_state(fsm_b), .coord_generator(crd_b), .rect_counter(rect_b),
        .batch_counter(bat_b), .batch_completed(bc_b), .busy(busy_b), .done(done_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected internal-phase tag for cycle k of a copy (k=0 is cycle C):
    // {fsm_state, coord, rect, batch, batch_completed}. Outside the copy: 0.
    function automatic logic [19:0] sb_of(input int k);
        int b, p;
        if (k < 0 || k > 8511) return '0;
        b = k / 2128;
        p = k % 2128;
        if (p < 80)
            return {3'(1 + p % 5), 10'd0, 4'(p / 5), 2'(b), 1'b0};
        else if (p < 1104)
            return {3'd6, 10'(p - 80), 4'd0, 2'(b), 1'b0};
        else
            return {3'd7, 10'(p - 1104), 4'd0, 2'(b), (p == 2127)};
    endfunction

    // Expected {mem_rd, mem_addr} at cycle k (k >= 0).
    function automatic logic [16:0] mem_of(input int k, input logic [15:0] base);
        int kk, b, p, off;
        kk  = (k > 8511) ? 8511 : k;
        b   = kk / 2128;
        p   = kk % 2128;
        off = b * 80 + ((p < 80) ? p : 79);
        return {(k <= 8511) && (p < 80), 16'(int'(base) + off)};
    endfunction

    // Expected {busy, done, copy_start} at cycle k (k >= 0).
    function automatic logic [2:0] ctl_of(input int k);
        return {(k <= 8512), (k == 8513), (k == 0)};
    endfunction

    task automatic check_cycle(input int k);
        chk($sformatf("memA@%0d", k), 64'({rd_a, addr_a}), 64'(mem_of(k, 16'h1000)));
        chk($sformatf("memB@%0d", k), 64'({rd_b, addr_b}), 64'(mem_of(k, 16'hFFF0)));
        chk($sformatf("sbA@%0d", k), 64'({fsm_a, crd_a, rect_a, bat_a, bc_a}), 64'(sb_of(k - 1)));
        chk($sformatf("sbB@%0d", k), 64'({fsm_b, crd_b, rect_b, bat_b, bc_b}), 64'(sb_of(k - 1)));
        chk($sformatf("ctlA@%0d", k), 64'({busy_a, done_a, cs_a}), 64'(ctl_of(k)));
        chk($sformatf("ctlB@%0d", k), 64'({busy_b, done_b, cs_b}), 64'(ctl_of(k)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_A"}, 64'({rd_a, addr_a, cs_a, fsm_a, crd_a, rect_a, bat_a, bc_a, busy_a, done_a}), 64'd0);
        chk({tag, "_B"}, 64'({rd_b, addr_b, cs_b, fsm_b, crd_b, rect_b, bat_b, bc_b, busy_b, done_b}), 64'd0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns positioned in cycle C.
    task automatic launch;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int n_bc;
    int n_done;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        #3;
        check_zero("reset_async");
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero("idle_after_reset");
        end

        // Full copy with stray starts while busy, including the last busy cycle.
        launch();
        n_bc   = 0;
        n_done = 0;
        for (int k = 0; k <= 8520; k++) begin
            check_cycle(k);
            if (bc_a) n_bc++;
            if (done_a) n_done++;
            if (k == 4275) chk("b2r3color_addr", 64'(addr_a), 64'h10B3);
            if (k == 4276) chk("b2r3color_sb", 64'({fsm_a, rect_a, bat_a}), 64'({3'd5, 4'd3, 2'd2}));
            if (k == 15) chk("wrap_ffff", 64'(addr_b), 64'hFFFF);
            if (k == 16) chk("wrap_0000", 64'(addr_b), 64'h0000);
            if (k == 2128) chk("b1_fetch_tag", 64'({fsm_a, bat_a}), 64'({3'd7, 2'd0}));
            if (k == 2129) chk("b1_first_sb", 64'({fsm_a, rect_a, bat_a}), 64'({3'd1, 4'd0, 2'd1}));
            start = (k == 100 || k == 3000 || k == 8512);
            tick();
        end
        start = 1'b0;
        chk("bc_pulses", 64'(n_bc), 64'd4);
        chk("done_pulses", 64'(n_done), 64'd1);

        // Reset in the middle of a copy: no done, clean restart afterwards.
        launch();
        for (int k = 0; k <= 600; k++) begin
            check_cycle(k);
            if (k < 600) tick();
        end
        #2 reset = 1'b1;
        #1 check_zero("reset_midop");
        tick();
        check_zero("reset_hold");
        tick();
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_zero("idle_after_abort");
            if (done_a) n_done++;
        end
        chk("no_done_after_abort", 64'(n_done), 64'd0);

        launch();
        for (int k = 0; k <= 200; k++) begin
            check_cycle(k);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
